// File: rtl/frame_streamer.sv
// frame_streamer
//   Streams a WIDTH x HEIGHT 8-bit frame out of a synchronous frame RAM and
//   into a downstream pixel FIFO in row-major order, one pixel per cycle
//   when the FIFO is not full. A start pulse in IDLE launches a frame; done
//   pulses for one cycle after the last FIFO write.
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   start        : frame start request, sampled only in IDLE
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse after the last pixel is written
//   mem_rd_en    : frame RAM read strobe
//   mem_rd_addr  : frame RAM address (row*WIDTH+col)
//   mem_rd_data  : RAM data, valid the cycle after a mem_rd_en cycle
//   out_wr_en    : downstream FIFO write strobe
//   out_full     : downstream FIFO full
//   out_din      : pixel written to the FIFO
module frame_streamer #(
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 720,
  parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [7:0]            mem_rd_data,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [7:0]            out_din
);

  localparam int PIXELS    = WIDTH * HEIGHT;
  localparam int CNT_WIDTH = $clog2(PIXELS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0]  FRAME_WRITES = CNT_WIDTH'(PIXELS);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_WIDTH-1:0]  wr_cnt;
  logic                  in_flight;   // a read was issued last cycle; its data is on mem_rd_data now

  // Two-entry holding buffer
  logic [7:0]            hold_q [2];
  logic                  head;
  logic [1:0]            occ;
  logic                  tail;

  logic                  push;
  logic                  pop;
  logic [1:0]            credit;
  logic                  drained;

  assign push = in_flight;
  assign pop  = (occ != 2'd0) && !out_full;
  assign tail = head ^ occ[0];

  assign out_wr_en   = pop;
  assign out_din     = hold_q[head];
  assign mem_rd_addr = rd_addr;

  // Credit counts slots already spoken for: buffered pixels plus the read in
  // flight, less the pixel leaving this cycle. Discounting the pop is what
  // lets a read issue every cycle in steady state while still guaranteeing a
  // returning pixel always finds a free slot if the FIFO fills afterwards.
  // pop implies occ >= 1, so the subtraction cannot underflow.
  assign credit    = occ + 2'(in_flight) - 2'(pop);
  assign mem_rd_en = (state == STREAM) && (credit < 2'd2);

  // Lookahead on the current cycle's pop so done follows the last write by
  // exactly one cycle.
  assign drained = (occ == 2'(pop)) && !in_flight &&
                   ((wr_cnt + CNT_WIDTH'(pop)) == FRAME_WRITES);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == FINISH);
    case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (mem_rd_en && (rd_addr == LAST_ADDR)) state_next = DRAIN;
      DRAIN:   if (drained) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      wr_cnt    <= '0;
      in_flight <= 1'b0;
    end else begin
      state     <= state_next;
      in_flight <= mem_rd_en;
      if ((state == IDLE) && start) begin
        rd_addr <= '0;
        wr_cnt  <= '0;
      end else begin
        // Saturates on the last pixel; the FSM leaves STREAM on that issue.
        if (mem_rd_en && (rd_addr != LAST_ADDR)) rd_addr <= rd_addr + 1'b1;
        if (pop) wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // NOTE: the buffer storage is reset along with its pointers because the
  // head entry drives out_din directly and must read 0 out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) hold_q[i] <= '0;
      head <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) hold_q[tail] <= mem_rd_data;
      if (pop)  head         <= ~head;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer on a 4x3 frame with RAM[i] = i+1.
// Cycle c0 is the cycle in which start is driven; all outputs are sampled
// on the falling edge and inputs change 1 time unit after the rising edge.
module tb_frame_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int AW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          out_wr_en;
  logic          out_full;
  logic [7:0]    out_din;

  frame_streamer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_wr_en   (out_wr_en),
    .out_full    (out_full),
    .out_din     (out_din)
  );

  always #5 clock = ~clock;

  // Frame RAM model: RAM[i] = i+1, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= 8'(mem_rd_addr) + 8'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-frame observation log
  int cyc;
  int n_wr, n_rd, seq_err, credit_viol, full_viol, max_out;
  int first_wr, last_wr, first_rd, first_rd_addr, last_rd_addr;
  int done_cnt, done_cyc, busy_first, busy_last, busy16, rd_after_done;
  int snap6;

  task automatic clear_log();
    cyc = 0; n_wr = 0; n_rd = 0; seq_err = 0; credit_viol = 0; full_viol = 0;
    max_out = 0; first_wr = -1; last_wr = -1; first_rd = -1; first_rd_addr = -1;
    last_rd_addr = -1; done_cnt = 0; done_cyc = -1; busy_first = -1;
    busy_last = -1; busy16 = -1; rd_after_done = -1; snap6 = -1;
  endtask

  // One clock cycle: apply inputs, sample on the falling edge, advance.
  task automatic step(input logic s, input logic f, input logic r);
    start = s; out_full = f; reset = r;
    @(negedge clock);
    if (out_wr_en) begin
      if (out_din !== 8'((n_wr % N) + 1)) seq_err++;
      if (out_full) full_viol++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (mem_rd_en) begin
      // Reads not yet written out, excluding the pixel leaving now.
      if ((n_rd - n_wr - int'(out_wr_en)) >= 2) credit_viol++;
      if (first_rd < 0) begin first_rd = cyc; first_rd_addr = int'(mem_rd_addr); end
      if (done_cnt == 1 && rd_after_done < 0) rd_after_done = cyc;
      last_rd_addr = int'(mem_rd_addr);
      n_rd++;
    end
    if (out_wr_en) n_wr++;
    if ((n_rd - n_wr) > max_out) max_out = n_rd - n_wr;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
    if (cyc == 16) busy16 = int'(busy);
    if (cyc == 6) snap6 = int'({busy, done, mem_rd_en, out_wr_en, mem_rd_addr, out_din});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // mode 0: no backpressure       1: out_full for c4..c9
  //      2: out_full alternating  3: start held through c16
  //      4: reset during c6..c7   5: random out_full
  task automatic run_frame(input int mode);
    int   phase;
    int   target;
    logic s, f, r;
    clear_log();
    phase  = int'($urandom_range(0, 1));
    target = (mode == 3) ? 2 : 1;
    for (int i = 0; i < 200; i++) begin
      s = (mode == 3) ? (cyc <= 16) : (cyc == 0);
      case (mode)
        1:       f = (cyc >= 4) && (cyc <= 9);
        2:       f = 1'((cyc + phase) % 2);
        5:       f = 1'($urandom_range(0, 1));
        default: f = 1'b0;
      endcase
      r = (mode == 4) && ((cyc == 6) || (cyc == 7));
      step(s, f, r);
      if (mode == 4 && cyc == 10) break;
      if (mode != 4 && done_cnt == target) break;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_full = 1'b0;
    @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_rd_addr", 32'(mem_rd_addr), 0);
    check("rst_wr_en", 32'(out_wr_en), 0);
    check("rst_din", 32'(out_din), 0);
    @(posedge clock);
    #1;
    clear_log();
    step(1'b0, 1'b0, 1'b0);
    check("idle_busy", 32'(busy_last), 32'(-1));
    check("idle_no_read", 32'(n_rd), 0);

    // Unthrottled frame
    run_frame(0);
    check("t0_writes", 32'(n_wr), N);
    check("t0_order", 32'(seq_err), 0);
    check("t0_first_wr", 32'(first_wr), 3);
    check("t0_last_wr", 32'(last_wr), 14);
    check("t0_done_cyc", 32'(done_cyc), 15);
    check("t0_done_cnt", 32'(done_cnt), 1);
    check("t0_busy_first", 32'(busy_first), 1);
    check("t0_busy_last", 32'(busy_last), 15);
    check("t0_first_rd", 32'(first_rd), 1);
    check("t0_first_addr", 32'(first_rd_addr), 0);
    check("t0_last_addr", 32'(last_rd_addr), N - 1);
    check("t0_reads", 32'(n_rd), N);
    check("t0_max_out", 32'(max_out), 2);
    check("t0_credit", 32'(credit_viol), 0);

    // FIFO full for c4..c9
    run_frame(1);
    check("t1_writes", 32'(n_wr), N);
    check("t1_order", 32'(seq_err), 0);
    check("t1_wr_when_full", 32'(full_viol), 0);
    check("t1_max_out", 32'(max_out), 2);
    check("t1_credit", 32'(credit_viol), 0);
    check("t1_last_wr", 32'(last_wr), 20);
    check("t1_done_cyc", 32'(done_cyc), 21);

    // Alternating and random backpressure
    for (int m = 2; m <= 5; m += 3) begin
      run_frame(m);
      check($sformatf("t%0d_writes", m), 32'(n_wr), N);
      check($sformatf("t%0d_order", m), 32'(seq_err), 0);
      check($sformatf("t%0d_credit", m), 32'(credit_viol), 0);
      check($sformatf("t%0d_wr_when_full", m), 32'(full_viol), 0);
      check($sformatf("t%0d_done_cnt", m), 32'(done_cnt), 1);
      check($sformatf("t%0d_done_after_wr", m), 32'(done_cyc), 32'(last_wr + 1));
    end

    // start held high: second frame only after done and a pass through IDLE
    run_frame(3);
    check("t3_writes", 32'(n_wr), 2 * N);
    check("t3_order", 32'(seq_err), 0);
    check("t3_busy_c16", 32'(busy16), 0);
    check("t3_restart_rd", 32'(rd_after_done), 17);
    check("t3_done_cnt", 32'(done_cnt), 2);
    check("t3_done_cyc", 32'(done_cyc), 31);

    // Reset mid-frame, then a fresh frame
    run_frame(4);
    check("t4_writes_before_rst", 32'(n_wr), 3);
    check("t4_outputs_in_rst", 32'(snap6), 0);
    check("t4_reads", 32'(n_rd), 5);
    check("t4_done_cnt", 32'(done_cnt), 0);
    run_frame(0);
    check("t4b_writes", 32'(n_wr), N);
    check("t4b_order", 32'(seq_err), 0);
    check("t4b_first_addr", 32'(first_rd_addr), 0);
    check("t4b_done_cyc", 32'(done_cyc), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
